// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor (d = a - b - bin), LSB first, start/done handshake; optional SERIAL_SUB_OVF_EN adds ovf
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, r_q, d_q;
  logic             br_q, bout_q;
  logic [CW-1:0]    cnt_q;

  logic             a0, b0, diff, br_next, last_bit;
  logic [WIDTH-1:0] r_next;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are captured separately because A/B shift out their MSBs.
  logic [1:0] msb_q;
  logic       ovf_q;
`endif

  // Full-subtractor cell on the current LSBs, plus the result shift-in value.
  always_comb begin
    a0       = a_q[0];
    b0       = b_q[0];
    diff     = a0 ^ b0 ^ br_q;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    r_next   = {diff, r_q[WIDTH-1:1]};
    last_bit = (cnt_q == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: capture on accepted start, shift one bit per SHIFT cycle, publish on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      msb_q  <= 2'b00;
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= bin;
            r_q   <= '0;
            cnt_q <= '0;
`ifdef SERIAL_SUB_OVF_EN
            msb_q <= {a[WIDTH-1], b[WIDTH-1]};
`endif
          end
        end
        S_SHIFT: begin
          a_q  <= {1'b0, a_q[WIDTH-1:1]};
          b_q  <= {1'b0, b_q[WIDTH-1:1]};
          br_q <= br_next;
          r_q  <= r_next;
          if (last_bit) begin
            // Counter parks at WIDTH-1; it is reloaded on the next start.
            d_q    <= r_next;
            bout_q <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= (msb_q[1] != msb_q[0]) && (diff != msb_q[1]);
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign d    = d_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH=8), directed vectors
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       bin = 1'b0;
  logic       busy, done, bout;
  logic [7:0] d;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] prev_d = 8'h00;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done cycle must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          e = sb_q.pop_front();
          chk("d", {24'h0, d}, {24'h0, e.d});
          chk("bout", {31'h0, bout}, {31'h0, e.bout});
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf", {31'h0, ovf}, {31'h0, e.ovf});
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       input logic [7:0] ed, input logic eb, input logic eo,
                       input int glitch_at, input int abort_at);
    int   cyc;
    bit   hold_ok, busy_ok, quiet_ok;
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    if (abort_at < 0) begin
      e.d = ed; e.bout = eb; e.ovf = eo;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ia; b = ~ib; bin = ~ibin;
    cyc = 0; hold_ok = 1'b1; busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (d !== prev_d) hold_ok = 1'b0;
      if (cyc == glitch_at) begin
        a = 8'hFF; b = 8'h00; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (cyc == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_d", {24'h0, d}, 32'h0);
        quiet_ok = 1'b1;
        repeat (12) begin
          if (done !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
          @(posedge clk);
          #1;
        end
        chk("abort_quiet", {31'h0, quiet_ok}, 32'h1);
        prev_d = 8'h00;
        return;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, 8);
    chk("busy_span", {31'h0, busy_ok}, 32'h1);
    chk("d_hold", {31'h0, hold_ok}, 32'h1);
    chk("busy_at_done", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    chk("done_pulse", {31'h0, done}, 32'h0);
    prev_d = ed;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_d", {24'h0, d}, 32'h0);
    chk("rst_bout", {31'h0, bout}, 32'h0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
`endif
    rst = 1'b0;

    do_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, -1, -1);
    do_op(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, -1, -1);
    do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, -1, -1);
    do_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 3, -1);
    do_op(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, -1, -1);
    do_op(8'h5A, 8'h23, 1'b0, 8'h00, 1'b0, 1'b0, -1, 4);
    do_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, -1, -1);
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, -1, -1);
    do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, -1, -1);
    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, -1, -1);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
